// File: rtl/rx_frame_sync.sv
// Rx frame synchroniser: sync-word search with Hamming tolerance and BPSK polarity
// resolution, then MSB-first packing of a fixed-length payload onto a byte stream.
module rx_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int          PAYLOAD_BYTES = 32,
  parameter int          MAX_ERR       = 1
) (
  input  logic        clk_32M768,
  input  logic        rst_n_32M768,
  input  logic        rx_bit,
  input  logic        rx_bit_valid,
  output logic [7:0]  data_tdata,
  output logic        data_tvalid,
  input  logic        data_tready,
  output logic        data_tuser,
  output logic        data_tlast,
  output logic        sync_locked,
  output logic        phase_inv,
  output logic [15:0] frame_cnt,
  output logic        overflow
);

  localparam logic [4:0] ERR_LIM  = 5'(MAX_ERR);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic {SEARCH = 1'b0, PAYLOAD = 1'b1} state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  state_t      state, state_nxt;
  logic [1:0]  rst_pipe;
  logic        rst_n;
  // The oldest window bit is shifted out by the very strobe that evaluates it,
  // so only 15 bits are stored; the full window is sr_nxt.
  logic [14:0] sr;
  logic [15:0] sr_nxt;
  logic [4:0]  d_pos, d_neg;
  logic        lock_pos, lock_neg;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_idx;
  logic [6:0]  byte_sr;
  logic [7:0]  byte_nxt;
  logic        byte_done, last_byte, frame_end;

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) rst_pipe <= 2'b00;
    else               rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  assign sr_nxt    = {sr, rx_bit};
  assign d_pos     = popcount16(sr_nxt ^ SYNC_WORD);
  assign d_neg     = popcount16(sr_nxt ^ ~SYNC_WORD);
  assign lock_pos  = (state == SEARCH) && rx_bit_valid && (d_pos <= ERR_LIM);
  assign lock_neg  = (state == SEARCH) && rx_bit_valid && (d_neg <= ERR_LIM);
  assign byte_nxt  = {byte_sr, rx_bit ^ phase_inv};
  assign byte_done = (state == PAYLOAD) && rx_bit_valid && (bit_cnt == 3'd7);
  assign last_byte = (byte_idx == LAST_IDX);
  assign frame_end = byte_done && last_byte;

  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (lock_pos || lock_neg) state_nxt = PAYLOAD;
      PAYLOAD: if (frame_end)            state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    sync_locked = (state == PAYLOAD);
  end

  // Stage p0: bit capture, byte assembly and frame bookkeeping
  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      byte_sr   <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      phase_inv <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (frame_end)         sr <= '0;
      else if (rx_bit_valid) sr <= sr_nxt[14:0];
      if (lock_pos || lock_neg) begin
        phase_inv <= !lock_pos;
        bit_cnt   <= '0;
        byte_idx  <= '0;
      end
      if ((state == PAYLOAD) && rx_bit_valid) begin
        byte_sr <= byte_nxt[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Index advances even when a byte is dropped, keeping frame boundaries aligned
      if (byte_done) byte_idx <= last_byte ? 8'd0 : byte_idx + 8'd1;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Stage p1: output register with valid/ready hold and sticky drop flag
  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      data_tdata  <= '0;
      data_tvalid <= 1'b0;
      data_tuser  <= 1'b0;
      data_tlast  <= 1'b0;
      overflow    <= 1'b0;
    end else if (byte_done) begin
      if (!data_tvalid || data_tready) begin
        data_tdata  <= byte_nxt;
        data_tvalid <= 1'b1;
        data_tuser  <= (byte_idx == 8'd0);
        data_tlast  <= last_byte;
      end else begin
        overflow <= 1'b1;
      end
    end else if (data_tvalid && data_tready) begin
      data_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_frame_sync.sv
// Bench for rx_frame_sync: randomized bit timing and payloads, checked against a
// stream-level model that locates sync words by index and slices bytes arithmetically.
`timescale 1ns/1ps
module tb_rx_frame_sync;

  localparam logic [15:0] SYNC = 16'hEB90;
  localparam int          PB   = 32;
  localparam int          MAXE = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_bit = 1'b0;
  logic        rx_bit_valid = 1'b0;
  logic        data_tready = 1'b1;
  logic [7:0]  data_tdata;
  logic        data_tvalid, data_tuser, data_tlast;
  logic        sync_locked, phase_inv, overflow;
  logic [15:0] frame_cnt;

  rx_frame_sync #(.SYNC_WORD(SYNC), .PAYLOAD_BYTES(PB), .MAX_ERR(MAXE)) dut (
    .clk_32M768   (clk),
    .rst_n_32M768 (rst_n),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .data_tdata   (data_tdata),
    .data_tvalid  (data_tvalid),
    .data_tready  (data_tready),
    .data_tuser   (data_tuser),
    .data_tlast   (data_tlast),
    .sync_locked  (sync_locked),
    .phase_inv    (phase_inv),
    .frame_cnt    (frame_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       user;
    logic       last;
  } beat_t;

  beat_t obs[$];
  logic  obs_lock[$];
  beat_t exp_q[$];
  bit    stream[$];
  int    drops[$];
  int    exp_frames;
  logic  exp_phase;
  int    checked;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Output monitor: collects accepted beats and checks hold-while-stalled
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [10:0] prev_b = '0;
  always @(negedge clk) begin
    if (rst_n && prev_v && !prev_r)
      chk("hold", 32'({data_tvalid, data_tuser, data_tlast, data_tdata}), 32'(prev_b));
    if (data_tvalid && data_tready) begin
      obs.push_back('{data_tdata, data_tuser, data_tlast});
      obs_lock.push_back(sync_locked);
    end
    prev_v = data_tvalid;
    prev_r = data_tready;
    prev_b = {data_tvalid, data_tuser, data_tlast, data_tdata};
  end

  function automatic bit is_sync(input logic [15:0] w);
    return ($countones(w ^ SYNC) <= MAXE) || ($countones(w ^ ~SYNC) <= MAXE);
  endfunction

  // Reference: scan the bit stream since reset for the first sync window
  // (zero-filled before each search start), then slice payload bytes by index.
  task automatic run_model();
    int          start, i, n, k, base;
    logic [15:0] w;
    logic [7:0]  v;
    logic        inv, lock;
    exp_q.delete();
    exp_frames = 0;
    exp_phase  = 1'b0;
    start = 0;
    i = 0;
    n = stream.size();
    while (i < n) begin
      w = '0;
      for (int j = 0; j < 16; j++) begin
        k = i - 15 + j;
        w = {w[14:0], (k >= start) ? logic'(stream[k]) : 1'b0};
      end
      lock = 1'b1;
      if ($countones(w ^ SYNC) <= MAXE)       inv = 1'b0;
      else if ($countones(w ^ ~SYNC) <= MAXE) inv = 1'b1;
      else begin
        lock = 1'b0;
        inv  = 1'b0;
      end
      if (!lock) begin
        i++;
        continue;
      end
      exp_phase = inv;
      for (int b = 0; b < PB; b++) begin
        base = i + 1 + 8 * b;
        if (base + 7 >= n) break;
        v = '0;
        for (int t = 0; t < 8; t++) v = {v[6:0], logic'(stream[base + t]) ^ inv};
        exp_q.push_back('{v, b == 0, b == PB - 1});
      end
      if (i + 8 * PB < n) begin
        exp_frames++;
        start = i + 8 * PB + 1;
        i = start;
      end else begin
        i = n;
      end
    end
  endtask

  task automatic checkpoint(input string tag);
    beat_t eff[$];
    bit    skip;
    repeat (6) begin @(posedge clk); #2; end
    run_model();
    for (int i = 0; i < exp_q.size(); i++) begin
      skip = 1'b0;
      foreach (drops[d]) if (drops[d] == i) skip = 1'b1;
      if (!skip) eff.push_back(exp_q[i]);
    end
    chk($sformatf("%s_nbeats", tag), 32'(obs.size()), 32'(eff.size()));
    for (int i = checked; i < eff.size() && i < obs.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), 32'(obs[i]), 32'(eff[i]));
      chk($sformatf("%s_lock%0d", tag, i), 32'(obs_lock[i]), 32'(!eff[i].last));
    end
    checked = eff.size();
    chk($sformatf("%s_frames", tag), 32'(frame_cnt), 32'(exp_frames & 'hFFFF));
    chk($sformatf("%s_phase", tag), 32'(phase_inv), 32'(exp_phase));
  endtask

  // Called at posedge+2; leaves 0..2 idle cycles after each strobe
  task automatic send_bit(input logic b);
    rx_bit       = b;
    rx_bit_valid = 1'b1;
    stream.push_back(b);
    @(posedge clk); #2;
    rx_bit_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(data_tvalid), 0);
    chk({tag, "_tdata"},  32'(data_tdata), 0);
    chk({tag, "_tuser"},  32'(data_tuser), 0);
    chk({tag, "_tlast"},  32'(data_tlast), 0);
    chk({tag, "_locked"}, 32'(sync_locked), 0);
    chk({tag, "_phase"},  32'(phase_inv), 0);
    chk({tag, "_frames"}, 32'(frame_cnt), 0);
    chk({tag, "_ovf"},    32'(overflow), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [15:0] w;
    bit pre[$];
    bit clean;
    checked = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #2; end
    check_reset_outputs("reset");

    // Clean frame, lock timing around the final sync bit
    for (int i = 15; i >= 1; i--) send_bit(SYNC[i]);
    chk("t1_prelock", 32'(sync_locked), 0);
    send_bit(SYNC[0]);
    chk("t1_lockrise", 32'(sync_locked), 1);
    for (int b = 0; b < PB; b++) send_byte(8'(b));
    checkpoint("t1");
    chk("t1_ovf", 32'(overflow), 0);

    // Inverted sync and inverted payload
    send_word(~SYNC);
    for (int b = 0; b < PB; b++) send_byte(~8'(b));
    checkpoint("t2");

    // One bit error tolerated, two rejected
    send_word(SYNC ^ 16'h0001);
    for (int b = 0; b < PB; b++) send_byte(8'($urandom));
    checkpoint("t3a");
    send_word(SYNC ^ 16'h0003);
    for (int b = 0; b < 4; b++) send_byte(8'h00);
    checkpoint("t3b");
    chk("t3b_unlocked", 32'(sync_locked), 0);

    // Random prefix free of sync windows, then a frame
    for (int t = 0; t < 50; t++) begin
      pre.delete();
      w = '0;
      clean = 1'b1;
      for (int i = 0; i < 200; i++) begin
        pre.push_back(bit'($urandom_range(0, 1)));
        w = {w[14:0], logic'(pre[i])};
        if (is_sync(w)) clean = 1'b0;
      end
      if (clean) break;
    end
    foreach (pre[i]) send_bit(pre[i]);
    send_word(SYNC);
    for (int b = 0; b < PB; b++) send_byte(8'($urandom));
    checkpoint("t4");

    // Stall across two byte completions: byte 3 held, byte 4 dropped
    chk("t5_ovf_pre", 32'(overflow), 0);
    drops.push_back(exp_q.size() + 4);
    send_word(SYNC);
    for (int b = 0; b < PB; b++) begin
      v = 8'hA0 + 8'(b);
      for (int i = 7; i >= 0; i--) begin
        if (b == 3 && i == 4) data_tready = 1'b0;
        if (b == 5 && i == 4) data_tready = 1'b1;
        send_bit(v[i]);
      end
    end
    checkpoint("t5");
    chk("t5_ovf", 32'(overflow), 1);

    // Reset in the middle of a frame
    send_word(SYNC);
    for (int b = 0; b < 10; b++) send_byte(8'h40 + 8'(b));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checkpoint("t6pre");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_inrst");
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #2; end
    check_reset_outputs("t6_postrst");
    stream.delete();
    obs.delete();
    obs_lock.delete();
    drops.delete();
    checked = 0;
    send_word(SYNC);
    for (int b = 0; b < PB; b++) send_byte(8'h60 + 8'(b));
    checkpoint("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_sync.md
Name: rx_frame_sync

Overview:
- Sits directly downstream of the Rx demodulator and consumes its recovered serial bit stream (Rx_1bit qualified by Rx_valid).
- Searches for a sync word with a bounded bit-error tolerance and resolves the BPSK 180° phase ambiguity: an inverted sync match flips all payload bits.
- Packs a fixed-length payload MSB-first into bytes on an AXI-Stream-style byte output. tuser marks the first byte of a frame, tlast the last.

Parameters:
- SYNC_WORD, 16'hEB90, sync pattern, MSB received first.
- PAYLOAD_BYTES, 32, payload bytes per frame (range 1..255).
- MAX_ERR, 1, max Hamming distance accepted as a sync match (range 0..7).

Ports:
- clk_32M768  in  1  system clock; only clock in the block.
- rst_n_32M768  in  1  asynchronous active-low reset.
- rx_bit  in  1  demodulated bit.
- rx_bit_valid  in  1  one-cycle strobe qualifying rx_bit (about 1.024 MHz rate).
- data_tdata  out  8  payload byte.
- data_tvalid  out  1  byte valid.
- data_tready  in  1  downstream accept.
- data_tuser  out  1  first byte of frame.
- data_tlast  out  1  last byte of frame.
- sync_locked  out  1  high while in PAYLOAD state.
- phase_inv  out  1  polarity of the current/last lock (1 = inverted match).
- frame_cnt  out  16  count of completed frames; wraps from 0xFFFF to 0.
- overflow  out  1  sticky; a byte was dropped because the output was still stalled.

Behaviour:
- Reset (async assert, synchronous deassert inside the block): all outputs 0, state SEARCH, shift register 0, bit and byte counters 0.
- Shift register sr[15:0]: only on rx_bit_valid, sr <= {sr[14:0], rx_bit}. Cycles without the strobe change nothing.
- Match evaluation uses the updated value sr_n = {sr[14:0], rx_bit}:
  - d_pos = popcount(sr_n ^ SYNC_WORD)
  - d_neg = popcount(sr_n ^ ~SYNC_WORD)
- State SEARCH:
  - On a strobe with d_pos <= MAX_ERR: go to PAYLOAD, phase_inv <= 0.
  - Else, on a strobe with d_neg <= MAX_ERR: go to PAYLOAD, phase_inv <= 1.
  - Positive match has priority when both hold.
  - sync_locked rises the cycle after the matching strobe.
  - The bit that completes the sync word is not payload.
- State PAYLOAD:
  - Each strobe shifts (rx_bit ^ phase_inv) into the byte register, MSB first, and increments the 3-bit bit counter.
  - On the 8th bit the byte is complete. The next cycle it is loaded to data_tdata with data_tvalid=1.
    - data_tuser=1 iff byte index 0.
    - data_tlast=1 iff byte index PAYLOAD_BYTES-1.
  - After the last byte completes: state returns to SEARCH, sr cleared to 0, frame_cnt increments, sync_locked falls the same cycle data_tvalid rises for the last byte.
  - Sync words are not re-checked during PAYLOAD.
- Output handshake:
  - data_tvalid holds with tdata/tuser/tlast stable until data_tvalid && data_tready.
  - On the acceptance cycle tvalid drops unless a new byte loads in that same cycle; if it does, the new byte replaces the old and tvalid stays 1.
  - If a byte completes while tvalid=1 and tready=0: the new byte is dropped, overflow <= 1 (sticky until reset), the held byte is kept, byte index still advances so frame boundaries stay aligned.
  - If the dropped byte is the last of the frame, tlast is lost for that frame. frame_cnt still increments and the state still returns to SEARCH.
- rx_bit_valid on consecutive cycles is legal; each strobe is one bit.
- Mid-operation reset: immediate return to reset values. A partially assembled byte or frame is discarded and nothing is emitted.
- Timing: Hamming distance logic is combinational from sr_n and fits one 32.768 MHz cycle. No multicycle paths.

Test Plan:
- Feed 0xEB90 then 32 bytes 0x00..0x1F with data_tready=1 -> 32 beats in order; tuser on 0x00, tlast on 0x1F; frame_cnt=1; phase_inv=0; sync_locked high from the cycle after sync to the last byte.
- Feed ~0xEB90 (0x146F) then bit-inverted 0x00..0x1F -> tdata 0x00..0x1F; phase_inv=1.
- Sync with 1 flipped bit (0xEB91) -> lock. With 2 flipped bits (0xEB93) -> no lock, no output, sync_locked=0.
- Random 200-bit prefix with no sync pattern, then a valid frame -> exactly one frame of output; bits before the sync are ignored.
- data_tready=0 across two byte completions in one frame -> first byte held stable, second dropped, overflow=1; remaining bytes and tlast are correct once tready returns to 1.
- Assert rst_n_32M768=0 after byte 10 of a frame, then release and send a fresh frame -> no partial output; counters and flags are 0 before the new frame; new frame received intact; frame_cnt=1.
